fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
// - Output reorder buffer after the last radix-2 SDF butterfly stage of the 32-point FFT.
// - The pipeline delivers bins in bit-reversed order. This block reorders them into natural order (bin 0..N-1).
// - Ping-pong buffer: one bank fills from the pipeline while the other drains to the downstream consumer.
// PARAMETERS
// - N      32   FFT length (power of 2)
// - LOG2N  5    log2(N); address/index width
// - DW     18   sample width per component, signed 12.6 (FRAC=6 fractional bits)
// - FRAC   6    fractional bits; used only by the optional rounding feature
// PORTS
// - clk       in   1      rising-edge clock
// - rst       in   1      synchronous reset, active-high
// - in_valid  in   1      qualifies in_sof/in_r/in_i this cycle
// - in_sof    in   1      first bin of a frame (bit-reversed position 0); valid only with in_valid
// - in_r      in   DW     signed real part, from the last butterfly stage output
// - in_i      in   DW     signed imaginary part
// - out_valid out  1      out_* valid this cycle; no back-pressure
// - out_r     out  DW     signed real part, natural order
// - out_i     out  DW     signed imaginary part
// - out_idx   out  LOG2N  bin index of the out_* sample (0..N-1)
// - err_sof   out  1      sticky: in_sof seen while a frame was partially written
// BEHAVIOUR
// - Reset (rst=1 at an edge): all outputs 0, write count 0, write bank 0, no bank full, err_sof 0.
//   Memory contents are don't-care.
// - Write side:
//   - The k-th accepted sample of a frame (k=0..N-1) is stored at address bitrev_LOG2N(k) in the write bank.
//   - Gaps in in_valid are allowed; the count advances only on accepted samples.
//   - Before the first in_sof after reset, samples without in_sof are dropped.
// - in_sof with count != 0: the partial frame is discarded, err_sof is set, and the sample is taken as k=0 of a new frame.
//   in_sof with count == 0 is normal.
// - Frame complete: on the edge accepting k=N-1, the write bank is marked full, the banks swap, and the count returns to 0.
// - Read side (FSM):
//   - RD_IDLE -> RD_RUN when a bank is full.
//   - RD_RUN reads addresses 0..N-1 on consecutive cycles, then returns to RD_IDLE.
//   - At the end of RD_RUN it re-enters RD_RUN directly if the other bank is already full.
// - Latency: if the last sample (k=N-1) is accepted in cycle c, out_valid=1 with out_idx=0 in cycle c+2.
//   out_valid stays high through cycle c+N+1 with out_idx incrementing by 1.
// - Outputs are registered. When out_valid=0, out_r, out_i and out_idx hold 0.
// - Simultaneous read and write: legal and required. The write bank is never the read bank.
//   At the maximum rate of 1 sample/cycle, frame m+1 completes no earlier than the draining of frame m.
//   Back-to-back frames therefore give a continuous out_valid, with no overflow.
// - Overrun: if both banks are full and a further sample arrives, that sample is dropped and err_sof is set.
// - Reset mid-drain: out_valid drops the cycle after the reset edge, and both banks are discarded.
// - err_sof clears only on rst.
// CONFIGURATION
// - REORDER_ROUND_EN defined:
//   - out_r and out_i are rounded to an integer: (x + 2^(FRAC-1)), then the FRAC LSBs are cleared.
//   - If the add overflows positive, the result saturates to the largest integer value: 0x1FFC0 for DW=18, FRAC=6.
//   - Rounding is applied in the output register stage, so latency is unchanged.
// - REORDER_ROUND_EN undefined: out_r and out_i are bit-exact copies of the stored samples.
// TESTING
// - Reset, then in_sof + 32 samples with in_r=k*64, in_i=-k*64 (k=0..31) -> two cycles after k=31,
//   32 cycles of out_idx=n with out_r=bitrev5(n)*64 and out_i=-bitrev5(n)*64. err_sof=0.
// - Two back-to-back frames at full rate, frame B = frame A + 1 (LSB) -> 64 consecutive out_valid cycles,
//   frame A reordered then frame B, no gap.
// - Same frame with in_valid toggling 1/0 -> identical output data. out_valid starts two cycles after the last accepted sample.
// - in_sof after 10 samples, then a full 32-sample frame -> err_sof=1, exactly one 32-sample output burst containing only the new frame.
// - rst asserted at out_idx=15 -> out_valid=0 on the next cycle, no further output, err_sof=0.
// - (REORDER_ROUND_EN) in_r=0x00020 (0.5) -> 0x00040; in_r=0x3FFDF (-0.515625) -> 0x3FFC0 (-1);
//   in_r=0x1FFFF -> 0x1FFC0 (saturated).

Source files
------------

// File: rtl/fft_out_reorder.sv
// Natural-order reorder buffer behind the last SDF stage of a 32-point FFT; ping-pong banks, first bin out 2 cycles after the last write.
// Optional build macro REORDER_ROUND_EN rounds out_r/out_i to integers in the output register stage.
module fft_out_reorder #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 18,
  parameter int FRAC  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [DW-1:0]    in_r,
  input  logic [DW-1:0]    in_i,
  output logic             out_valid,
  output logic [DW-1:0]    out_r,
  output logic [DW-1:0]    out_i,
  output logic [LOG2N-1:0] out_idx,
  output logic             err_sof
);

`ifdef REORDER_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

  logic [2*DW-1:0]  mem [2*N];
  logic [LOG2N-1:0] wr_cnt, wr_k, wr_addr;
  logic             wr_bank, started, wr_acc, wr_done, overrun;
  logic [1:0]       full;
  logic             rd_bank, rd_run, rd_last, rd_bank_ready, oth_bank_ready;
  logic [LOG2N-1:0] rd_addr;
  logic [2*DW-1:0]  rd_dat;
  rd_state_t        state, state_nx;

  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] x);
    logic [DW-1:0] s;
    s = x + DW'(1 << (FRAC - 1));
    if (!ROUND_EN) return x;
    // Only a non-negative input can wrap when adding one half.
    if (!x[DW-1] && s[DW-1]) return {1'b0, {(DW-1-FRAC){1'b1}}, {FRAC{1'b0}}};
    return {s[DW-1:FRAC], {FRAC{1'b0}}};
  endfunction

  always_comb begin
    wr_k = in_sof ? '0 : wr_cnt;
    for (int b = 0; b < LOG2N; b++) wr_addr[b] = wr_k[LOG2N-1-b];
    wr_acc  = in_valid && (started || in_sof) && !full[wr_bank];
    overrun = in_valid && full[wr_bank];
    wr_done = wr_acc && (&wr_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      started <= 1'b0;
      err_sof <= 1'b0;
    end else begin
      if (wr_acc && in_sof) started <= 1'b1;
      if (wr_acc) begin
        wr_cnt <= wr_done ? '0 : wr_k + 1'b1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if ((wr_acc && in_sof && wr_cnt != '0) || overrun) err_sof <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_bank, wr_addr}] <= {in_r, in_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_done && wr_bank == b[0])      full[b] <= 1'b1;
        else if (rd_last && rd_bank == b[0]) full[b] <= 1'b0;
      end
    end
  end

  // A bank completing this cycle counts as ready so the drain starts one cycle sooner.
  always_comb begin
    rd_bank_ready  = full[rd_bank]  || (wr_done && wr_bank == rd_bank);
    oth_bank_ready = full[~rd_bank] || (wr_done && wr_bank != rd_bank);
    rd_last        = rd_run && (&rd_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RD_IDLE: if (rd_bank_ready) state_nx = RD_RUN;
      RD_RUN:  if (&rd_addr) state_nx = oth_bank_ready ? RD_RUN : RD_IDLE;
      default: state_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_run = (state == RD_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else if (rd_run) begin
      rd_addr <= rd_addr + 1'b1;
      if (rd_last) rd_bank <= ~rd_bank;
    end
  end

  assign rd_dat = mem[{rd_bank, rd_addr}];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      out_valid <= rd_run;
      out_idx   <= rd_run ? rd_addr : '0;
      out_r     <= rd_run ? fmt(rd_dat[2*DW-1:DW]) : '0;
      out_i     <= rd_run ? fmt(rd_dat[DW-1:0]) : '0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: vector table for the frame data plus hand-written multi-cycle sequences.
module tb_fft_out_reorder;
  localparam int N = 32, LOG2N = 5, DW = 18;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sof, out_valid, err_sof;
  logic [DW-1:0]    in_r, in_i, out_r, out_i;
  logic [LOG2N-1:0] out_idx;

  fft_out_reorder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    in_r;
    logic [DW-1:0]    in_i;
    logic [LOG2N-1:0] exp_idx;
    logic [DW-1:0]    exp_r;
    logic [DW-1:0]    exp_i;
  } vec_t;

  typedef struct {
    int            k;
    int            idx;
    logic [DW-1:0] in_r;
    logic [DW-1:0] exp_r;
  } rnd_t;

  vec_t vt [N];
  rnd_t rt [3];

  int vecs = 0, errs = 0, cyc = 0, idle_bad = 0, t_last = 0;
  int             cap_cyc [$];
  int             cap_idx [$];
  logic [DW-1:0]  cap_r   [$];
  logic [DW-1:0]  cap_i   [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_cyc.push_back(cyc);
      cap_idx.push_back(int'(out_idx));
      cap_r.push_back(out_r);
      cap_i.push_back(out_i);
    end else if (out_r != '0 || out_i != '0 || out_idx != '0) begin
      idle_bad++;
    end
  end

  function automatic int bitrev5(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (k & (1 << b)) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  // Expected output formatting: identity, or round-half-up to a multiple of 64 with positive saturation.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] x);
`ifdef REORDER_ROUND_EN
    int v;
    v = int'($signed(x)) + 32;
    if (v > 131071) return 18'h1FFC0;
    v = v & ~63;
    return DW'(v);
`else
    return x;
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cap_cyc.delete(); cap_idx.delete(); cap_r.delete(); cap_i.delete();
  endtask

  task automatic send(input logic sof, input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_valid = 1'b1; in_sof = sof; in_r = r; in_i = i;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
    t_last = cyc;
  endtask

  task automatic send_frame(input int add, input bit gap);
    for (int k = 0; k < N; k++) begin
      send(k == 0, vt[k].in_r + DW'(add), vt[k].in_i + DW'(add));
      if (gap && k != N - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_caps(input int n, input int budget);
    for (int t = 0; t < budget && cap_idx.size() < n; t++) @(negedge clk);
  endtask

  task automatic check_burst(input string nm, input int base, input int add, input int t0);
    check({nm, "_count"}, (cap_idx.size() >= base + N) ? 1 : 0, 1);
    if (cap_idx.size() < base + N) return;
    check({nm, "_start"}, cap_cyc[base], t0);
    check({nm, "_end"}, cap_cyc[base+N-1], t0 + N - 1);
    for (int n = 0; n < N; n++) begin
      check({nm, "_idx"}, cap_idx[base+n], int'(vt[n].exp_idx));
      check({nm, "_r"}, int'(cap_r[base+n]), int'(model(vt[n].exp_r + DW'(add))));
      check({nm, "_i"}, int'(cap_i[base+n]), int'(model(vt[n].exp_i + DW'(add))));
    end
  endtask

  initial begin
    int t_a, n_caps;
    bit hit;

    for (int k = 0; k < N; k++) begin
      vt[k].in_r    = DW'(k * 64);
      vt[k].in_i    = DW'(-k * 64);
      vt[k].exp_idx = LOG2N'(k);
      vt[k].exp_r   = DW'(bitrev5(k) * 64);
      vt[k].exp_i   = DW'(-bitrev5(k) * 64);
    end
`ifdef REORDER_ROUND_EN
    rt[0] = '{0, 0,  18'h00020, 18'h00040};
    rt[1] = '{1, 16, 18'h3FFDF, 18'h3FFC0};
    rt[2] = '{2, 8,  18'h1FFFF, 18'h1FFC0};
`else
    rt[0] = '{0, 0,  18'h00020, 18'h00020};
    rt[1] = '{1, 16, 18'h3FFDF, 18'h3FFDF};
    rt[2] = '{2, 8,  18'h1FFFF, 18'h1FFFF};
`endif

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_idx", int'(out_idx), 0);
    check("rst_r", int'(out_r), 0);
    check("rst_err", int'(err_sof), 0);

    // Single frame at full rate
    @(posedge clk); #1;
    send_frame(0, 1'b0);
    wait_caps(N, 60);
    check_burst("frame", 0, 0, t_last + 1);
    check("frame_err", int'(err_sof), 0);

    // Back-to-back frames, B = A + 1
    do_reset();
    send_frame(0, 1'b0);
    t_a = t_last;
    send_frame(1, 1'b0);
    wait_caps(2 * N, 100);
    check_burst("b2b_a", 0, 0, t_a + 1);
    check_burst("b2b_b", N, 1, t_last + 1);

    // Samples before the first in_sof are dropped, then a frame with in_valid toggling
    do_reset();
    for (int k = 0; k < 5; k++) send(1'b0, 18'h00100, 18'h00100);
    send_frame(0, 1'b1);
    wait_caps(N, 60);
    check_burst("gap", 0, 0, t_last + 1);
    check("gap_err", int'(err_sof), 0);

    // Early in_sof: partial frame discarded, only the new frame comes out
    do_reset();
    for (int k = 0; k < 10; k++) send(k == 0, 18'h00555, 18'h00AAA);
    send_frame(0, 1'b0);
    wait_caps(N, 60);
    repeat (50) @(negedge clk);
    check("early_sof_err", int'(err_sof), 1);
    check("early_sof_bursts", cap_idx.size(), N);
    check_burst("early_sof", 0, 0, t_last + 1);

    // Reset in the middle of a drain
    do_reset();
    send_frame(0, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 60 && !hit; t++) begin
      @(negedge clk);
      hit = out_valid && out_idx == 5'd15;
    end
    check("mid_rst_reach15", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_err", int'(err_sof), 0);
    n_caps = cap_idx.size();
    repeat (50) @(negedge clk);
    check("mid_rst_silent", cap_idx.size(), n_caps);

    // Rounding corner values
    do_reset();
    for (int k = 0; k < N; k++) begin
      logic [DW-1:0] r;
      r = '0;
      for (int j = 0; j < 3; j++) if (rt[j].k == k) r = rt[j].in_r;
      send(k == 0, r, '0);
    end
    wait_caps(N, 60);
    check("rnd_count", (cap_idx.size() >= N) ? 1 : 0, 1);
    if (cap_idx.size() >= N) begin
      for (int j = 0; j < 3; j++) begin
        check("rnd_idx", cap_idx[rt[j].idx], rt[j].idx);
        check("rnd_r", int'(cap_r[rt[j].idx]), int'(rt[j].exp_r));
      end
    end

    check("idle_outputs_zero", idle_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
